// File: rtl/demux_1_8_32bit_buf.sv
// Buffered 1-to-8 demultiplexer: one producer steers a word into one of eight
// holding slots, each drained independently by its consumer via valid/ack.
module demux_1_8_32bit_buf #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           sel,
    input  logic [WIDTH-1:0]     src_in,
    output logic [7:0]           out_valid,
    input  logic [7:0]           out_ack,
    output logic [8*WIDTH-1:0]   z,
    output logic [3:0]           fill_cnt,
    output logic                 all_full
);

    logic [WIDTH-1:0] slot_q [8];
    logic             acc;
    logic             acc_new;
    logic [7:0]       acc_vec;
    logic [7:0]       drn_vec;
    logic [7:0]       valid_next;
    logic [3:0]       drn_cnt;
    logic [3:0]       fill_next;

    assign in_ready = ~out_valid[sel] | out_ack[sel];
    assign acc      = in_valid & in_ready;

    // A slot refilled in the same cycle it drains stays valid, so it is
    // excluded from the drain count and does not count as newly valid.
    always_comb begin
        acc_vec = '0;
        if (acc) begin
            acc_vec[sel] = 1'b1;
        end
        drn_vec    = out_valid & out_ack & ~acc_vec;
        acc_new    = acc & ~out_valid[sel];
        valid_next = (out_valid & ~drn_vec) | acc_vec;
        drn_cnt    = '0;
        for (int k = 0; k < 8; k++) begin
            drn_cnt = drn_cnt + {3'b000, drn_vec[k]};
        end
        fill_next = fill_cnt + {3'b000, acc_new} - drn_cnt;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int k = 0; k < 8; k++) begin
                slot_q[k] <= '0;
            end
            out_valid <= '0;
            fill_cnt  <= '0;
            all_full  <= 1'b0;
        end else begin
            if (acc) begin
                slot_q[sel] <= src_in;
            end
            out_valid <= valid_next;
            fill_cnt  <= fill_next;
            all_full  <= (fill_next == 4'd8);
        end
    end

    for (genvar k = 0; k < 8; k++) begin : g_z
        assign z[WIDTH*k +: WIDTH] = slot_q[k];
    end

endmodule

// File: tb/tb_demux_1_8_32bit_buf.sv
// Self-checking bench for demux_1_8_32bit_buf: directed test-plan steps followed
// by random traffic, all compared against a slot-array reference model.
module tb_demux_1_8_32bit_buf;

    localparam int WIDTH = 32;

    logic               clk = 1'b0;
    logic               nrst;
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         sel;
    logic [WIDTH-1:0]   src_in;
    logic [7:0]         out_valid;
    logic [7:0]         out_ack;
    logic [8*WIDTH-1:0] z;
    logic [3:0]         fill_cnt;
    logic               all_full;

    int total = 0;
    int bad   = 0;

    // reference model
    logic [WIDTH-1:0] m_data [8];
    bit               m_valid [8];

    demux_1_8_32bit_buf #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .src_in    (src_in),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .z         (z),
        .fill_cnt  (fill_cnt),
        .all_full  (all_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_valid_vec();
        logic [7:0] v = '0;
        for (int k = 0; k < 8; k++) v[k] = m_valid[k];
        return v;
    endfunction

    function automatic logic [255:0] m_z();
        logic [255:0] r = '0;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = m_data[k];
        return r;
    endfunction

    function automatic int m_fill();
        int n = 0;
        for (int k = 0; k < 8; k++) n += int'(m_valid[k]);
        return n;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 8; k++) begin
            m_data[k]  = '0;
            m_valid[k] = 1'b0;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".out_valid"}, 256'(out_valid), 256'(m_valid_vec()));
        check({tag, ".z"},         256'(z),         m_z());
        check({tag, ".fill_cnt"},  256'(fill_cnt),  256'(m_fill()));
        check({tag, ".all_full"},  256'(all_full),  256'(m_fill() == 8));
    endtask

    // One cycle: drive at negedge, check in_ready combinationally, clock,
    // advance the model, then check registered outputs after the edge.
    task automatic step(input string tag, input bit v, input logic [2:0] s,
                        input logic [31:0] d, input logic [7:0] a);
        bit rdy;
        bit accept;
        @(negedge clk);
        in_valid = v;
        sel      = s;
        src_in   = d;
        out_ack  = a;
        #1;
        rdy = !m_valid[s] || a[s];
        check({tag, ".in_ready"}, 256'(in_ready), 256'(rdy));
        accept = v && rdy;
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            if (accept && s == 3'(k)) begin
                m_data[k]  = d;
                m_valid[k] = 1'b1;
            end else if (a[k]) begin
                m_valid[k] = 1'b0;
            end
        end
        #1;
        check_state(tag);
    endtask

    task automatic fill_all(input string tag);
        for (int k = 0; k < 8; k++) begin
            step(tag, 1'b1, 3'(k), 32'hA000_0000 + 32'(k), 8'h00);
        end
    endtask

    initial begin
        logic [7:0] ack;
        in_valid = 1'b0;
        sel      = '0;
        src_in   = '0;
        out_ack  = '0;
        nrst     = 1'b0;
        m_reset();
        #2;
        check_state("por");
        check("por.in_ready", 256'(in_ready), 256'(1));
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;

        // fill all slots
        fill_all("fill");
        check("fill.valid_ff", 256'(out_valid), 256'(8'hFF));
        check("fill.z3", 256'(z[32*3 +: 32]), 256'(32'hA000_0003));
        check("fill.full", 256'(all_full), 256'(1));

        // stall on occupied slot
        step("stall", 1'b1, 3'd3, 32'hDEAD_BEEF, 8'h00);
        check("stall.z3", 256'(z[32*3 +: 32]), 256'(32'hA000_0003));

        // same-slot collision: refill while draining
        step("collide", 1'b1, 3'd3, 32'hDEAD_BEEF, 8'h08);
        check("collide.z3", 256'(z[32*3 +: 32]), 256'(32'hDEAD_BEEF));
        check("collide.fill", 256'(fill_cnt), 256'(8));

        // concurrent drains with accept to a free slot
        step("drain_lo", 1'b0, 3'd0, 32'h0, 8'h0F);
        check("drain_lo.valid", 256'(out_valid), 256'(8'hF0));
        step("conc", 1'b1, 3'd0, 32'h1234_5678, 8'hF0);
        check("conc.valid", 256'(out_valid), 256'(8'h01));
        check("conc.fill", 256'(fill_cnt), 256'(1));

        // spurious acks while idle
        step("drain0", 1'b0, 3'd5, 32'h0, 8'h01);
        step("spur", 1'b0, 3'd6, 32'hFFFF_FFFF, 8'hFF);
        check("spur.fill", 256'(fill_cnt), 256'(0));

        // random traffic
        for (int i = 0; i < 400; i++) begin
            ack = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            step("rand", 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                 32'($urandom), ack);
        end

        // async reset mid-transfer with slots full
        fill_all("refill");
        @(negedge clk);
        in_valid = 1'b1;
        sel      = 3'd2;
        src_in   = 32'hCAFE_F00D;
        out_ack  = 8'h00;
        #2;
        nrst = 1'b0;
        m_reset();
        #1;
        check_state("areset");
        check("areset.in_ready", 256'(in_ready), 256'(1));
        @(posedge clk);
        #1;
        check_state("areset_hold");
        @(negedge clk);
        nrst     = 1'b1;
        in_valid = 1'b0;
        step("post_rst", 1'b1, 3'd7, 32'h0BAD_CAFE, 8'h00);
        check("post_rst.z7", 256'(z[32*7 +: 32]), 256'(32'h0BAD_CAFE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
